wb_port_arbiter: RTL

Shares a small number of write-back bus ports among more functional-unit requesters than there are ports, e.g. MUL, DIV, CSR and FMISC sharing two ports. It sits between the FU outputs and the WriteBackBus, alongside the fixed ALU/LSU write-back paths. Each requester gets a one-entry holding register with a valid/ready handshake. Each cycle up to PORT_NUM held results are granted, and results younger than a redirect are squashed. Granted results drive registered bus ports.

---
 rtl/wb_port_arbiter_if.sv | 40 ++++
 rtl/wb_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundles the requester-side handshake, the redirect input and the
//   registered write-back ports of wb_port_arbiter.
//   master : the environment (functional units, backend, WriteBackBus)
//   slave  : the arbiter itself
//   Signals:
//     req_valid/req_ready          per-requester valid/ready handshake
//     req_rob_idx/req_rd/req_res   per-requester result payload
//     redirect_valid/_rob_idx      backend redirect (squash younger results)
//     wb_en/wb_we/wb_rob_idx/wb_rd/wb_res   per-port write-back outputs
interface wb_port_arbiter_if #(
  parameter int REQ_NUM   = 4,
  parameter int PORT_NUM  = 2,
  parameter int ROB_IDX_W = 6,
  parameter int PREG_W    = 7,
  parameter int DATA_W    = 32
);
  logic [REQ_NUM-1:0]                req_valid;
  logic [REQ_NUM-1:0]                req_ready;
  logic [REQ_NUM-1:0][ROB_IDX_W:0]   req_rob_idx;
  logic [REQ_NUM-1:0][PREG_W-1:0]    req_rd;
  logic [REQ_NUM-1:0][DATA_W-1:0]    req_res;
  logic                              redirect_valid;
  logic [ROB_IDX_W:0]                redirect_rob_idx;
  logic [PORT_NUM-1:0]               wb_en;
  logic [PORT_NUM-1:0]               wb_we;
  logic [PORT_NUM-1:0][ROB_IDX_W:0]  wb_rob_idx;
  logic [PORT_NUM-1:0][PREG_W-1:0]   wb_rd;
  logic [PORT_NUM-1:0][DATA_W-1:0]   wb_res;

  modport master (
    output req_valid, req_rob_idx, req_rd, req_res, redirect_valid, redirect_rob_idx,
    input  req_ready, wb_en, wb_we, wb_rob_idx, wb_rd, wb_res
  );

  modport slave (
    input  req_valid, req_rob_idx, req_rd, req_res, redirect_valid, redirect_rob_idx,
    output req_ready, wb_en, wb_we, wb_rob_idx, wb_rd, wb_res
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares PORT_NUM registered write-back ports among REQ_NUM functional-unit
//   requesters. Each requester owns a one-entry holding register; each cycle
//   up to PORT_NUM held, non-squashed entries are granted and latched into
//   the output registers. Entries younger than a redirect are squashed.
//   Ports:
//     clk  - clock
//     rst  - synchronous reset, active low
//     bus  - wb_port_arbiter_if.slave (request handshake, redirect, wb ports)
//   Configuration:
//     WB_ARB_OLDEST_FIRST_EN - when defined, grant the oldest eligible entries
//     (oldest on port 0) instead of round-robin; no rotation pointer is built.
module wb_port_arbiter #(
  parameter int REQ_NUM   = 4,
  parameter int PORT_NUM  = 2,
  parameter int ROB_IDX_W = 6,
  parameter int PREG_W    = 7,
  parameter int DATA_W    = 32
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  // a is younger than b; a differing wrap bit flips the index comparison
  function automatic logic younger(input logic [ROB_IDX_W:0] a, input logic [ROB_IDX_W:0] b);
    if (a[ROB_IDX_W] == b[ROB_IDX_W]) return a[ROB_IDX_W-1:0] > b[ROB_IDX_W-1:0];
    else                              return a[ROB_IDX_W-1:0] < b[ROB_IDX_W-1:0];
  endfunction

  logic [REQ_NUM-1:0]               hv_q, hv_d;
  logic [REQ_NUM-1:0][ROB_IDX_W:0]  rob_q, rob_d;
  logic [REQ_NUM-1:0][PREG_W-1:0]   rd_q, rd_d;
  logic [REQ_NUM-1:0][DATA_W-1:0]   res_q, res_d;

  logic [PORT_NUM-1:0]              wb_en_q, wb_en_d;
  logic [PORT_NUM-1:0]              wb_we_q, wb_we_d;
  logic [PORT_NUM-1:0][ROB_IDX_W:0] wb_rob_idx_q, wb_rob_idx_d;
  logic [PORT_NUM-1:0][PREG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [PORT_NUM-1:0][DATA_W-1:0]  wb_res_q, wb_res_d;

  logic [REQ_NUM-1:0]               kill, in_kill, elig, grant, ready;
  logic [PORT_NUM-1:0]              port_vld;
  logic [PORT_NUM-1:0][PTR_W-1:0]   port_sel;

  // Squash detection for held entries and for same-cycle incoming results
  always_comb begin
    kill    = '0;
    in_kill = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      kill[i]    = bus.redirect_valid & hv_q[i] & younger(rob_q[i], bus.redirect_rob_idx);
      in_kill[i] = bus.redirect_valid & younger(bus.req_rob_idx[i], bus.redirect_rob_idx);
    end
  end

  assign elig = hv_q & ~kill;

`ifdef WB_ARB_OLDEST_FIRST_EN
  int older_cnt;

  // An entry's port is its age rank among eligible entries (rob_idx unique)
  always_comb begin
    grant     = '0;
    port_vld  = '0;
    port_sel  = '0;
    older_cnt = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      older_cnt = 0;
      for (int j = 0; j < REQ_NUM; j++) begin
        if (elig[j] && younger(rob_q[i], rob_q[j])) older_cnt++;
      end
      if (elig[i] && older_cnt < PORT_NUM) begin
        grant[i]            = 1'b1;
        port_vld[older_cnt] = 1'b1;
        port_sel[older_cnt] = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  int               n_granted;
  int               scan_idx;

  // Cyclic scan from rr_ptr; j-th grant goes to port j, pointer follows last grant
  always_comb begin
    grant     = '0;
    port_vld  = '0;
    port_sel  = '0;
    rr_ptr_d  = rr_ptr_q;
    n_granted = 0;
    scan_idx  = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= REQ_NUM) scan_idx -= REQ_NUM;
      if (elig[scan_idx] && n_granted < PORT_NUM) begin
        grant[scan_idx]     = 1'b1;
        port_vld[n_granted] = 1'b1;
        port_sel[n_granted] = PTR_W'(scan_idx);
        rr_ptr_d            = (scan_idx == REQ_NUM - 1) ? '0 : PTR_W'(scan_idx + 1);
        n_granted++;
      end
    end
  end

  // Rotation pointer register
  always_ff @(posedge clk) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign ready         = ~hv_q | grant | kill;
  assign bus.req_ready = ready;

  // Holding registers: freed by kill/grant, reloaded on accept unless the
  // incoming result is itself squashed (acked but dropped)
  always_comb begin
    hv_d  = hv_q & ~(kill | grant);
    rob_d = rob_q;
    rd_d  = rd_q;
    res_d = res_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (bus.req_valid[i] && ready[i]) begin
        hv_d[i]  = ~in_kill[i];
        rob_d[i] = bus.req_rob_idx[i];
        rd_d[i]  = bus.req_rd[i];
        res_d[i] = bus.req_res[i];
      end
    end
  end

  // Output port payload; unused ports keep their old payload with en=0
  always_comb begin
    wb_en_d      = port_vld;
    wb_we_d      = '0;
    wb_rob_idx_d = wb_rob_idx_q;
    wb_rd_d      = wb_rd_q;
    wb_res_d     = wb_res_q;
    for (int k = 0; k < PORT_NUM; k++) begin
      if (port_vld[k]) begin
        wb_rob_idx_d[k] = rob_q[port_sel[k]];
        wb_rd_d[k]      = rd_q[port_sel[k]];
        wb_res_d[k]     = res_q[port_sel[k]];
        wb_we_d[k]      = (rd_q[port_sel[k]] != '0);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      hv_q         <= '0;
      rob_q        <= '0;
      rd_q         <= '0;
      res_q        <= '0;
      wb_en_q      <= '0;
      wb_we_q      <= '0;
      wb_rob_idx_q <= '0;
      wb_rd_q      <= '0;
      wb_res_q     <= '0;
    end else begin
      hv_q         <= hv_d;
      rob_q        <= rob_d;
      rd_q         <= rd_d;
      res_q        <= res_d;
      wb_en_q      <= wb_en_d;
      wb_we_q      <= wb_we_d;
      wb_rob_idx_q <= wb_rob_idx_d;
      wb_rd_q      <= wb_rd_d;
      wb_res_q     <= wb_res_d;
    end
  end

  assign bus.wb_en      = wb_en_q;
  assign bus.wb_we      = wb_we_q;
  assign bus.wb_rob_idx = wb_rob_idx_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_res     = wb_res_q;

endmodule
